// File: rtl/data_sramlike_axi_bridge_if.sv
// Bus bundle for the data-side bridge: sram-like CPU port plus AXI3 master channels.
// "master" is the bridge's view; "slave" is the view of the CPU/interconnect around it.
interface data_sramlike_axi_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/data_sramlike_axi_bridge.sv
// Data-side sram-like to AXI3 bridge: one single-beat transaction in flight at a time.
//
// state        | meaning
// IDLE         | waiting for data_req; addr_ok follows req
// RD_ADDR      | presenting AR until arready
// RD_DATA      | waiting for rvalid; completes the load
// WR_ADDR_DATA | presenting AW and W independently until both handshake
// WR_RESP      | waiting for bvalid; completes the store
module data_sramlike_axi_bridge (
    input  logic                              clk,
    input  logic                              rst,
    data_sramlike_axi_bridge_if.master        bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_fin;
    logic        w_fin;
    logic        unused_resp;

    // Handshake completes either earlier (flag) or in this very cycle.
    assign aw_fin = aw_done | (state == WR_ADDR_DATA && bus.awready);
    assign w_fin  = w_done  | (state == WR_ADDR_DATA && bus.wready);

    assign unused_resp = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.data_req) begin
                size_q  <= bus.data_size;
                addr_q  <= bus.data_addr;
                wdata_q <= bus.data_wdata;
            end
            if (state == WR_ADDR_DATA) begin
                if (aw_fin && w_fin) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                end
            end
        end
    end

    always_comb begin
        state_next       = state;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.arvalid      = 1'b0;
        bus.rready       = 1'b0;
        bus.awvalid      = 1'b0;
        bus.wvalid       = 1'b0;
        bus.bready       = 1'b0;
        case (state)
            IDLE: begin
                bus.data_addr_ok = bus.data_req;
                if (bus.data_req) begin
                    state_next = bus.data_wr ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    bus.data_data_ok = 1'b1;
                    state_next       = IDLE;
                end
            end
            WR_ADDR_DATA: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
                if (aw_fin && w_fin) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    bus.data_data_ok = 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    bus.wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    bus.wstrb = 4'b0011 << addr_q[1:0];
            default: bus.wstrb = 4'b1111;
        endcase
    end

    assign bus.data_rdata = bus.rdata;

    assign bus.arid    = 4'd0;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;

    assign bus.awid    = 4'd0;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = 4'd0;
    assign bus.awsize  = {1'b0, size_q};
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'd0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;

    assign bus.wid   = 4'd0;
    assign bus.wdata = wdata_q;
    assign bus.wlast = 1'b1;
endmodule

// File: tb/tb_data_sramlike_axi_bridge.sv
// Bench for data_sramlike_axi_bridge: directed scenarios plus randomized loads/stores
// against a delay-parameterized AXI slave and a latency/strobe reference model.
`timescale 1ns/1ps
module tb_data_sramlike_axi_bridge;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_sramlike_axi_bridge_if bus();
    data_sramlike_axi_bridge dut (.clk(clk), .rst(rst), .bus(bus.master));

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    } txn_t;

    typedef struct {
        int          acc_cnt, ok_cnt, ok_cyc, ar_cyc, aw_cyc, w_cyc, b_first;
        int          hold_err, const_err;
        logic [31:0] rdata, addr, wdata;
        logic [2:0]  size;
        logic [3:0]  wstrb;
    } obs_t;

    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] base;
        int         sh;
        sh = addr % 4;
        if (size == 2'd0) base = 4'b0001;
        else if (size == 2'd1) base = 4'b0011;
        else return 4'b1111;
        return base << sh;
    endfunction

    function automatic int ref_latency(input txn_t t);
        if (t.wr) return 2 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
        return 2 + t.ar_dly + t.r_dly;
    endfunction

    task automatic idle_all();
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0;
        bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.rid = 4'd0; bus.rdata = 32'd0; bus.rresp = 2'd0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        bus.bid = 4'd0; bus.bresp = 2'd0; bus.bvalid = 1'b0;
    endtask

    // Issue one request at cycle 0 and play the AXI slave; called and returns at posedge+1.
    task automatic run_txn(input txn_t t, output obs_t o);
        int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        bit seen_ar = 0, seen_aw = 0, seen_w = 0;
        bit ar_pend = 0, aw_pend = 0, w_pend = 0;
        o = '{default: 0};
        o.ok_cyc = -1; o.ar_cyc = -1; o.aw_cyc = -1; o.w_cyc = -1; o.b_first = -1;
        bus.data_req = 1'b1; bus.data_wr = t.wr; bus.data_size = t.size;
        bus.data_addr = t.addr; bus.data_wdata = t.wdata;
        bus.rresp = t.resp; bus.bresp = t.resp; bus.rlast = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.arready = bus.arvalid && (ar_cnt >= t.ar_dly);
            bus.awready = bus.awvalid && (aw_cnt >= t.aw_dly);
            bus.wready  = bus.wvalid  && (w_cnt  >= t.w_dly);
            bus.rvalid  = bus.rready  && (r_cnt  >= t.r_dly);
            bus.rdata   = bus.rvalid ? t.rdata : $urandom;
            bus.bvalid  = bus.bready  && (b_cnt  >= t.b_dly);
            @(negedge clk);
            if (bus.data_addr_ok) o.acc_cnt++;
            if (bus.data_data_ok) begin
                o.ok_cnt++;
                if (o.ok_cyc < 0) begin o.ok_cyc = cyc; o.rdata = bus.data_rdata; end
            end
            if (bus.arvalid) begin
                if (!seen_ar) begin seen_ar = 1; o.addr = bus.araddr; o.size = bus.arsize; end
                else if (bus.araddr !== o.addr || bus.arsize !== o.size) o.hold_err++;
                if (bus.arlen !== 4'd0 || bus.arburst !== 2'b01 || bus.arid !== 4'd0 ||
                    bus.arlock !== 2'd0 || bus.arcache !== 4'd0 || bus.arprot !== 3'd0 || t.wr)
                    o.const_err++;
                if (bus.arready) o.ar_cyc = cyc; else ar_cnt++;
            end else if (ar_pend) o.hold_err++;
            ar_pend = bus.arvalid && !bus.arready;
            if (bus.awvalid) begin
                if (!seen_aw) begin seen_aw = 1; o.addr = bus.awaddr; o.size = bus.awsize; end
                else if (bus.awaddr !== o.addr || bus.awsize !== o.size) o.hold_err++;
                if (bus.awlen !== 4'd0 || bus.awburst !== 2'b01 || bus.awid !== 4'd0 ||
                    bus.awlock !== 2'd0 || bus.awcache !== 4'd0 || bus.awprot !== 3'd0 || !t.wr)
                    o.const_err++;
                if (bus.awready) o.aw_cyc = cyc; else aw_cnt++;
            end else if (aw_pend) o.hold_err++;
            aw_pend = bus.awvalid && !bus.awready;
            if (bus.wvalid) begin
                if (!seen_w) begin seen_w = 1; o.wdata = bus.wdata; o.wstrb = bus.wstrb; end
                else if (bus.wdata !== o.wdata || bus.wstrb !== o.wstrb) o.hold_err++;
                if (bus.wlast !== 1'b1 || bus.wid !== 4'd0 || !t.wr) o.const_err++;
                if (bus.wready) o.w_cyc = cyc; else w_cnt++;
            end else if (w_pend) o.hold_err++;
            w_pend = bus.wvalid && !bus.wready;
            if (bus.rready && t.wr) o.const_err++;
            if (bus.bready && !t.wr) o.const_err++;
            if (bus.rready && !bus.rvalid) r_cnt++;
            if (bus.bready && o.b_first < 0) o.b_first = cyc;
            if (bus.bready && !bus.bvalid) b_cnt++;
            @(posedge clk); #1;
            if (cyc == 0) begin
                bus.data_req = 1'b0; bus.data_wr = $urandom; bus.data_size = 2'($urandom);
                bus.data_addr = $urandom; bus.data_wdata = $urandom;
            end
            if (o.ok_cyc >= 0 && cyc >= o.ok_cyc + 2) break;
        end
        idle_all();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok, bus.data_addr_ok} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok, bus.data_addr_ok});
        end
        checks++;
        if (bus.araddr !== 32'd0 || bus.awaddr !== 32'd0 || bus.wdata !== 32'd0 || bus.arsize !== 3'd0) begin
            failures++;
            $display("FAIL reset_fields got araddr=%h awaddr=%h wdata=%h arsize=%0d want all 0",
                     bus.araddr, bus.awaddr, bus.wdata, bus.arsize);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        bus.data_req = 1'b1;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL idle_addr_ok got %b want 1", bus.data_addr_ok);
        end
        bus.data_req = 1'b0;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL idle_addr_ok_low got %b want 0", bus.data_addr_ok);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        txn_t t;
        obs_t o;
        t = '{wr: 1'b0, size: 2'd2, addr: 32'h1000, wdata: 32'd0, rdata: 32'hDEADBEEF, resp: 2'd0,
              ar_dly: 0, r_dly: 0, aw_dly: 0, w_dly: 0, b_dly: 0};
        run_txn(t, o);
        checks++;
        if (o.addr !== 32'h1000 || o.size !== 3'd2) begin
            failures++;
            $display("FAIL load_ar got addr=%h size=%0d want 1000 2", o.addr, o.size);
        end
        checks++;
        if (o.ok_cyc !== 2 || o.ok_cnt !== 1 || o.ar_cyc !== 1) begin
            failures++;
            $display("FAIL load_latency got ok_cyc=%0d ok_cnt=%0d ar_cyc=%0d want 2 1 1", o.ok_cyc, o.ok_cnt, o.ar_cyc);
        end
        checks++;
        if (o.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_rdata got %h want deadbeef", o.rdata);
        end
    endtask

    task automatic test_store_byte_late_aw();
        txn_t t;
        obs_t o;
        t = '{wr: 1'b1, size: 2'd0, addr: 32'h2003, wdata: 32'hAB000000, rdata: 32'd0, resp: 2'd0,
              ar_dly: 0, r_dly: 0, aw_dly: 3, w_dly: 0, b_dly: 1};
        run_txn(t, o);
        checks++;
        if (o.wstrb !== 4'b1000 || o.size !== 3'd0 || o.wdata !== 32'hAB000000 || o.addr !== 32'h2003) begin
            failures++;
            $display("FAIL store_byte_fields got wstrb=%b size=%0d wdata=%h addr=%h want 1000 0 ab000000 2003",
                     o.wstrb, o.size, o.wdata, o.addr);
        end
        checks++;
        if (o.w_cyc !== 1 || o.aw_cyc !== 4 || o.hold_err !== 0) begin
            failures++;
            $display("FAIL store_byte_hold got w_cyc=%0d aw_cyc=%0d hold_err=%0d want 1 4 0", o.w_cyc, o.aw_cyc, o.hold_err);
        end
        checks++;
        if (o.ok_cnt !== 1 || o.ok_cyc !== 6) begin
            failures++;
            $display("FAIL store_byte_done got ok_cnt=%0d ok_cyc=%0d want 1 6", o.ok_cnt, o.ok_cyc);
        end
    endtask

    task automatic test_store_half_same_cycle();
        txn_t t;
        obs_t o;
        t = '{wr: 1'b1, size: 2'd1, addr: 32'h2002, wdata: 32'h12340000, rdata: 32'd0, resp: 2'd0,
              ar_dly: 0, r_dly: 0, aw_dly: 1, w_dly: 1, b_dly: 0};
        run_txn(t, o);
        checks++;
        if (o.wstrb !== 4'b1100 || o.size !== 3'd1) begin
            failures++;
            $display("FAIL store_half_strb got wstrb=%b size=%0d want 1100 1", o.wstrb, o.size);
        end
        checks++;
        if (o.aw_cyc !== 2 || o.w_cyc !== 2 || o.b_first !== 3 || o.ok_cyc !== 3) begin
            failures++;
            $display("FAIL store_half_resp got aw=%0d w=%0d b_first=%0d ok=%0d want 2 2 3 3",
                     o.aw_cyc, o.w_cyc, o.b_first, o.ok_cyc);
        end
    endtask

    task automatic test_bresp_error();
        txn_t t;
        obs_t o;
        t = '{wr: 1'b1, size: 2'd2, addr: 32'h3000, wdata: 32'hCAFEF00D, rdata: 32'd0, resp: 2'b10,
              ar_dly: 0, r_dly: 0, aw_dly: 0, w_dly: 2, b_dly: 2};
        run_txn(t, o);
        checks++;
        if (o.ok_cnt !== 1 || o.acc_cnt !== 1 || o.ok_cyc !== 6) begin
            failures++;
            $display("FAIL bresp_err got ok_cnt=%0d acc_cnt=%0d ok_cyc=%0d want 1 1 6", o.ok_cnt, o.acc_cnt, o.ok_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int          acc_q[$];
        int          ok_q[$];
        logic [31:0] rd = 32'd0;
        logic [31:0] aw_addr = 32'd0;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2;
        bus.data_addr = 32'h4000; bus.data_wdata = 32'd0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.arready = bus.arvalid;
            bus.awready = bus.awvalid;
            bus.wready  = bus.wvalid;
            bus.rvalid  = bus.rready;
            bus.rdata   = bus.rvalid ? 32'h5A5A1234 : 32'h0;
            bus.bvalid  = bus.bready;
            @(negedge clk);
            if (bus.data_addr_ok) acc_q.push_back(cyc);
            if (bus.data_data_ok) begin
                ok_q.push_back(cyc);
                if (ok_q.size() == 1) rd = bus.data_rdata;
            end
            if (bus.awvalid) aw_addr = bus.awaddr;
            @(posedge clk); #1;
            if (acc_q.size() == 1) begin
                bus.data_wr = 1'b1; bus.data_addr = 32'h4444; bus.data_wdata = 32'h77;
            end else if (acc_q.size() >= 2) begin
                bus.data_req = 1'b0;
            end
        end
        idle_all();
        checks++;
        if (!(acc_q.size() == 2 && acc_q[0] == 0 && acc_q[1] == 3)) begin
            failures++;
            $display("FAIL b2b_addr_ok got n=%0d first=%0d second=%0d want 2 0 3", acc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : -1, (acc_q.size() > 1) ? acc_q[1] : -1);
        end
        checks++;
        if (!(ok_q.size() == 2 && ok_q[0] == 2 && ok_q[1] == 5)) begin
            failures++;
            $display("FAIL b2b_data_ok got n=%0d first=%0d second=%0d want 2 2 5", ok_q.size(),
                     (ok_q.size() > 0) ? ok_q[0] : -1, (ok_q.size() > 1) ? ok_q[1] : -1);
        end
        checks++;
        if (rd !== 32'h5A5A1234 || aw_addr !== 32'h4444) begin
            failures++;
            $display("FAIL b2b_payload got rdata=%h awaddr=%h want 5a5a1234 4444", rd, aw_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        txn_t t;
        obs_t o;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h5000;
        @(negedge clk);
        @(posedge clk); #1;
        bus.data_req = 1'b0;
        bus.arready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.arready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rready !== 1'b1 || bus.data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pre got rready=%b data_ok=%b want 1 0", bus.rready, bus.data_data_ok);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok} !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid_post got %b want 000000",
                     {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_data_ok});
        end
        @(posedge clk); #1;
        t = '{wr: 1'b0, size: 2'd1, addr: 32'h6002, wdata: 32'd0, rdata: 32'h0BADCAFE, resp: 2'd0,
              ar_dly: 1, r_dly: 1, aw_dly: 0, w_dly: 0, b_dly: 0};
        run_txn(t, o);
        checks++;
        if (o.ok_cnt !== 1 || o.ok_cyc !== 4 || o.rdata !== 32'h0BADCAFE) begin
            failures++;
            $display("FAIL rst_recover got ok_cnt=%0d ok_cyc=%0d rdata=%h want 1 4 0badcafe", o.ok_cnt, o.ok_cyc, o.rdata);
        end
    endtask

    task automatic test_random();
        txn_t t;
        obs_t o;
        int   exp_cyc;
        for (int i = 0; i < 40; i++) begin
            t.wr = $urandom_range(0, 1);
            t.size = 2'($urandom_range(0, 3));
            t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
            t.resp = 2'($urandom);
            t.ar_dly = $urandom_range(0, 3); t.r_dly = $urandom_range(0, 3);
            t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3);
            t.b_dly = $urandom_range(0, 3);
            exp_cyc = ref_latency(t);
            run_txn(t, o);
            checks++;
            if (o.ok_cnt !== 1 || o.acc_cnt !== 1 || o.ok_cyc !== exp_cyc) begin
                failures++;
                $display("FAIL rand%0d_done got ok_cnt=%0d acc_cnt=%0d ok_cyc=%0d want 1 1 %0d",
                         i, o.ok_cnt, o.acc_cnt, o.ok_cyc, exp_cyc);
            end
            checks++;
            if (o.addr !== t.addr || o.size !== {1'b0, t.size}) begin
                failures++;
                $display("FAIL rand%0d_addr got addr=%h size=%0d want %h %0d", i, o.addr, o.size, t.addr, t.size);
            end
            checks++;
            if (t.wr && (o.wdata !== t.wdata || o.wstrb !== ref_strb(t.size, t.addr))) begin
                failures++;
                $display("FAIL rand%0d_wdata got wdata=%h wstrb=%b want %h %b",
                         i, o.wdata, o.wstrb, t.wdata, ref_strb(t.size, t.addr));
            end else if (!t.wr && o.rdata !== t.rdata) begin
                failures++;
                $display("FAIL rand%0d_rdata got %h want %h", i, o.rdata, t.rdata);
            end
            checks++;
            if (o.hold_err !== 0 || o.const_err !== 0) begin
                failures++;
                $display("FAIL rand%0d_axi_rules got hold_err=%0d const_err=%0d want 0 0", i, o.hold_err, o.const_err);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_store_byte_late_aw();
        test_store_half_same_cycle();
        test_bresp_error();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
